// File: rtl/soc_boot_ctrl.sv
// soc_boot_ctrl
// Boot sequencer between the FPGA clocking resources and the SoC. It waits for
// the clock wizard to lock and then holds the SoC in reset for a fixed
// interval. After that it releases the reset. It raises fetch-enable on a
// debounced button press. It also generates a divided reference clock, which
// is gated by the boot state. Any loss of lock restarts the sequence.
//
// Ports:
//   soc_clk      in   SoC clock
//   rst_n        in   asynchronous active-low reset
//   locked_i     in   clock wizard lock (asynchronous)
//   fetch_btn_i  in   fetch push-button, active-high (asynchronous, bouncing)
//   soc_rst_no   out  SoC reset, active-low (registered)
//   fetch_en_o   out  SoC fetch enable (registered)
//   rtc_clk_o    out  divided reference clock (registered)
//   state_o      out  current state: 0 WAIT_LOCK, 1 RESET_HOLD, 2 IDLE, 3 RUN
//
// Build option: define SOC_BOOT_CTRL_AUTOFETCH_EN to go from IDLE to RUN
// unconditionally. This removes the button synchroniser and the debouncer.
module soc_boot_ctrl #(
  parameter int unsigned SyncStages      = 2,
  parameter int unsigned ResetHoldCycles = 64,
  parameter int unsigned DebounceCycles  = 20000,
  parameter int unsigned RtcDiv          = 610
) (
  input  logic       soc_clk,
  input  logic       rst_n,
  input  logic       locked_i,
  input  logic       fetch_btn_i,
  output logic       soc_rst_no,
  output logic       fetch_en_o,
  output logic       rtc_clk_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    RESET_HOLD = 2'd1,
    IDLE       = 2'd2,
    RUN        = 2'd3
  } state_e;

  localparam int unsigned HoldW = (ResetHoldCycles > 1) ? $clog2(ResetHoldCycles) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(ResetHoldCycles - 1);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);
  localparam int unsigned RtcW = ((RtcDiv / 2) > 1) ? $clog2(RtcDiv / 2) : 1;
  localparam logic [RtcW-1:0] RtcLast = RtcW'(RtcDiv / 2 - 1);
  localparam logic [RtcW-1:0] RtcOne  = RtcW'(1);

  state_e                state_q, state_d;
  logic [SyncStages-1:0] lock_sync_q, lock_sync_d;
  logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [RtcW-1:0]       rtc_cnt_q, rtc_cnt_d;
  logic                  rtc_clk_q, rtc_clk_d;
  logic                  soc_rst_n_q, soc_rst_n_d;
  logic                  fetch_en_q, fetch_en_d;
  logic                  lock_s;
  logic                  go_s;

  assign lock_s = lock_sync_q[SyncStages-1];

`ifdef SOC_BOOT_CTRL_AUTOFETCH_EN
  assign go_s = 1'b1;
`else
  localparam int unsigned DbW = $clog2(DebounceCycles + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DebounceCycles - 1);
  localparam logic [DbW-1:0] DbOne  = DbW'(1);

  logic [SyncStages-1:0] btn_sync_q, btn_sync_d;
  logic [DbW-1:0]        db_cnt_q, db_cnt_d;
  logic                  btn_db_q, btn_db_d;
  logic                  btn_rise_q, btn_rise_d;
  logic                  btn_s;

  assign btn_s = btn_sync_q[SyncStages-1];
  // Registered btn_rise means the FSM acts one edge after acceptance.
  assign go_s  = btn_rise_q;

  // Button synchroniser, debounce counter and rising-edge detect.
  always_comb begin
    btn_sync_d = {btn_sync_q[SyncStages-2:0], fetch_btn_i};
    btn_db_d   = btn_db_q;
    db_cnt_d   = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DbLast) begin
        btn_db_d = btn_s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DbOne;
      end
    end else begin
      db_cnt_d = '0;
    end
    btn_rise_d = btn_db_d & ~btn_db_q;
  end

  // Button path state.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q <= '0;
      db_cnt_q   <= '0;
      btn_db_q   <= 1'b0;
      btn_rise_q <= 1'b0;
    end else begin
      btn_sync_q <= btn_sync_d;
      db_cnt_q   <= db_cnt_d;
      btn_db_q   <= btn_db_d;
      btn_rise_q <= btn_rise_d;
    end
  end
`endif

  // Next-state logic. Lock loss overrides every other transition.
  always_comb begin
    lock_sync_d = {lock_sync_q[SyncStages-2:0], locked_i};
    state_d     = state_q;
    hold_cnt_d  = '0;
    if (!lock_s) begin
      state_d = WAIT_LOCK;
    end else begin
      case (state_q)
        WAIT_LOCK:  state_d = RESET_HOLD;
        RESET_HOLD: begin
          if (hold_cnt_q == HoldLast) begin
            state_d = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldOne;
          end
        end
        // A held button gives no new edge here, so it cannot start RUN.
        IDLE: begin
          if (go_s) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  // Outputs are computed from the next state, so they change on the same
  // edge as the state. The RTC divider starts counting on the cycle after
  // IDLE is entered, which puts the first rise RtcDiv/2 edges after entry.
  always_comb begin
    soc_rst_n_d = state_d[1];
    fetch_en_d  = (state_d == RUN);
    rtc_cnt_d   = '0;
    rtc_clk_d   = 1'b0;
    if (!state_d[1]) begin
      rtc_cnt_d = '0;
      rtc_clk_d = 1'b0;
    end else if (state_q[1]) begin
      if (rtc_cnt_q == RtcLast) begin
        rtc_cnt_d = '0;
        rtc_clk_d = ~rtc_clk_q;
      end else begin
        rtc_cnt_d = rtc_cnt_q + RtcOne;
        rtc_clk_d = rtc_clk_q;
      end
    end else begin
      rtc_cnt_d = '0;
      rtc_clk_d = rtc_clk_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      lock_sync_q <= '0;
      hold_cnt_q  <= '0;
      rtc_cnt_q   <= '0;
      rtc_clk_q   <= 1'b0;
      soc_rst_n_q <= 1'b0;
      fetch_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_sync_q <= lock_sync_d;
      hold_cnt_q  <= hold_cnt_d;
      rtc_cnt_q   <= rtc_cnt_d;
      rtc_clk_q   <= rtc_clk_d;
      soc_rst_n_q <= soc_rst_n_d;
      fetch_en_q  <= fetch_en_d;
    end
  end

  assign soc_rst_no = soc_rst_n_q;
  assign fetch_en_o = fetch_en_q;
  assign rtc_clk_o  = rtc_clk_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// Directed testbench for soc_boot_ctrl with SyncStages=2, ResetHoldCycles=8,
// DebounceCycles=4, RtcDiv=10. Inputs change and outputs are sampled 1 ns
// after the rising edge.
module tb_soc_boot_ctrl;

  logic       soc_clk;
  logic       rst_n;
  logic       locked_i;
  logic       fetch_btn_i;
  logic       soc_rst_no;
  logic       fetch_en_o;
  logic       rtc_clk_o;
  logic [1:0] state_o;

  int n_total = 0;
  int n_bad   = 0;

  soc_boot_ctrl #(
    .SyncStages      (2),
    .ResetHoldCycles (8),
    .DebounceCycles  (4),
    .RtcDiv          (10)
  ) dut (
    .soc_clk     (soc_clk),
    .rst_n       (rst_n),
    .locked_i    (locked_i),
    .fetch_btn_i (fetch_btn_i),
    .soc_rst_no  (soc_rst_no),
    .fetch_en_o  (fetch_en_o),
    .rtc_clk_o   (rtc_clk_o),
    .state_o     (state_o)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge soc_clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic rn,
                            input logic fe, input logic rc);
    check_val({tag, ".state"}, 32'(state_o), 32'(st));
    check_val({tag, ".soc_rst_no"}, 32'(soc_rst_no), 32'(rn));
    check_val({tag, ".fetch_en"}, 32'(fetch_en_o), 32'(fe));
    check_val({tag, ".rtc_clk"}, 32'(rtc_clk_o), 32'(rc));
  endtask

  initial begin
    rst_n       = 1'b0;
    locked_i    = 1'b0;
    fetch_btn_i = 1'b0;
    tick(3);
    check_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(10);
    check_outs("no_lock", 2'd0, 1'b0, 1'b0, 1'b0);

    // Lock rises at cycle 10: RESET_HOLD at 13, release at 21.
    locked_i = 1'b1;
    tick(2);
    check_val("lock_sync_state", 32'(state_o), 32'd0);
    tick(1);
    check_outs("hold_entry", 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check_val("hold_rtc_low", 32'(rtc_clk_o), 32'd0);
      check_val("hold_rst_low", 32'(soc_rst_no), 32'd0);
    end
    tick(1);
`ifdef SOC_BOOT_CTRL_AUTOFETCH_EN
    check_outs("release", 2'd2, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_outs("autofetch", 2'd3, 1'b1, 1'b1, 1'b0);
    tick(3);
`else
    check_outs("release", 2'd2, 1'b1, 1'b0, 1'b0);

    // RTC: low for 4 more edges, then toggles every 5.
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      check_val("rtc_wave", 32'(rtc_clk_o), 32'((k / 5) % 2));
      check_val("idle_no_fetch", 32'(fetch_en_o), 32'd0);
    end

    // Bounce: toggles every 2 cycles for 20 cycles, then holds 1.
    for (int i = 0; i < 20; i++) begin
      fetch_btn_i = ((i / 2) % 2 == 0);
      tick(1);
      check_val("bounce_no_fetch", 32'(fetch_en_o), 32'd0);
    end
    fetch_btn_i = 1'b1;
    tick(6);
    check_val("press_pre_fetch", 32'(fetch_en_o), 32'd0);
    check_val("press_pre_state", 32'(state_o), 32'd2);
    tick(1);
    check_val("press_fetch", 32'(fetch_en_o), 32'd1);
    check_val("press_state", 32'(state_o), 32'd3);

    // Lock loss in RUN: outputs drop three edges later.
    locked_i = 1'b0;
    tick(2);
    check_val("loss_pre_fetch", 32'(fetch_en_o), 32'd1);
    tick(1);
    check_outs("lock_loss", 2'd0, 1'b0, 1'b0, 1'b0);

    // Re-lock repeats the 8-cycle hold; the still-held button does not fetch.
    locked_i = 1'b1;
    tick(3);
    check_val("relock_hold", 32'(state_o), 32'd1);
    tick(7);
    check_val("relock_pre_rel", 32'(soc_rst_no), 32'd0);
    tick(1);
    check_outs("relock_rel", 2'd2, 1'b1, 1'b0, 1'b0);

    // Button held through reset and lock: no RUN until re-pressed.
    #3;
    rst_n       = 1'b0;
    locked_i    = 1'b0;
    fetch_btn_i = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    locked_i = 1'b1;
    tick(3);
    check_val("held_hold", 32'(state_o), 32'd1);
    tick(8);
    check_val("held_idle_rst", 32'(soc_rst_no), 32'd1);
    tick(20);
    check_val("held_state", 32'(state_o), 32'd2);
    check_val("held_fetch", 32'(fetch_en_o), 32'd0);
    fetch_btn_i = 1'b0;
    tick(10);
    check_val("released_state", 32'(state_o), 32'd2);
    fetch_btn_i = 1'b1;
    tick(6);
    check_val("repress_pre", 32'(fetch_en_o), 32'd0);
    tick(1);
    check_val("repress_fetch", 32'(fetch_en_o), 32'd1);
    check_val("repress_state", 32'(state_o), 32'd3);
    tick(3);
`endif

    // Mid-run asynchronous reset clears outputs immediately.
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 2'd0, 1'b0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/soc_boot_ctrl.md
# soc_boot_ctrl

Boot sequencer between the FPGA clocking resources and the Croc SoC on the Zybo top level. It waits for the clock wizard to lock, holds the SoC in reset for a fixed interval, releases it, then raises fetch-enable on a debounced button press. It also generates the ~32.768 kHz reference clock for the SoC, gated by the boot state. Any loss of lock returns the sequence to its start.

## Interface
- SyncStages, 2: flip-flop stages on each asynchronous input; at least 2.
- ResetHoldCycles, 64: soc_clk cycles spent in RESET_HOLD; at least 1.
- DebounceCycles, 20000: stable-sample count required before the button state is accepted; at least 1.
- RtcDiv, 610: soc_clk-to-rtc_clk_o division ratio; even, at least 2.

Ports:
- soc_clk  in  1  SoC clock (20 MHz from the clock wizard).
- rst_n  in  1  Reset, asynchronous, active-low; clock soc_clk.
- locked_i  in  1  Clock wizard lock; asynchronous.
- fetch_btn_i  in  1  Fetch push-button, active-high; asynchronous and bouncing.
- soc_rst_no  out  1  SoC reset, active-low; registered.
- fetch_en_o  out  1  SoC fetch enable; registered.
- rtc_clk_o  out  1  Divided reference clock; registered.
- state_o  out  2  Current state encoding, for the status LED and debug.

## Operation
- Synchronisers: locked_i and fetch_btn_i each pass through SyncStages flops, reset to 0. The synchronised signals are lock_s and btn_s.
- Debounce:
  - Counter width is $clog2(DebounceCycles+1).
  - When btn_s differs from btn_db, the counter increments. When they are equal, the counter clears.
  - On reaching DebounceCycles-1 while they still differ, btn_db takes btn_s and the counter clears.
  - btn_rise is asserted for one cycle when btn_db goes 0 to 1.
- FSM states and encodings: WAIT_LOCK = 0, RESET_HOLD = 1, IDLE = 2, RUN = 3.
  - WAIT_LOCK -> RESET_HOLD when lock_s = 1. The hold counter clears.
  - RESET_HOLD -> IDLE when the hold counter = ResetHoldCycles-1. Otherwise the counter increments.
  - IDLE -> RUN on btn_rise.
  - RUN stays in RUN; there is no software or button exit.
  - From any state, lock_s = 0 sends the FSM to WAIT_LOCK. This has priority over every other transition.
- Outputs:
  - soc_rst_no = 1 only in IDLE and RUN.
  - fetch_en_o = 1 only in RUN.
  - Both are registered from the next state, so they change on the same edge as the state.
- Button handling outside IDLE:
  - btn_rise in WAIT_LOCK or RESET_HOLD is discarded.
  - A button held down through entry into IDLE does not start RUN. A new rising edge is required.
- RTC divider:
  - Counter width is $clog2(RtcDiv/2).
  - The counter and rtc_clk_o are held at 0 in WAIT_LOCK and RESET_HOLD.
  - In IDLE and RUN the counter counts 0 to RtcDiv/2-1; at terminal count it wraps to 0 and rtc_clk_o toggles.
  - Duty cycle is 50%. rtc_clk_o period = RtcDiv soc_clk cycles.

## Timing
- Reset values: soc_rst_no = 0, fetch_en_o = 0, rtc_clk_o = 0, state_o = 0. All counters and synchroniser flops are 0.
- Reset acts asynchronously on assertion. Mid-operation reset forces all of the above immediately.
- Lock-to-release latency: locked_i rises, then after SyncStages edges lock_s = 1.
  - The next edge enters RESET_HOLD.
  - soc_rst_no rises exactly ResetHoldCycles edges later.
- Button-to-fetch latency: a clean press is accepted SyncStages + DebounceCycles edges after fetch_btn_i rises. btn_rise is asserted on that edge, and fetch_en_o rises on the following edge.
- Lock loss: SyncStages edges after locked_i falls, the next edge forces soc_rst_no = 0, fetch_en_o = 0 and rtc_clk_o = 0 together.
- Glitch filtering: a bounce shorter than DebounceCycles samples never changes btn_db.
- First rtc_clk_o edge: rtc_clk_o first rises RtcDiv/2 cycles after entering IDLE.

## Configuration
- Macro: SOC_BOOT_CTRL_AUTOFETCH_EN.
- Defined:
  - IDLE -> RUN unconditionally on the next edge, so fetch_en_o rises one cycle after soc_rst_no.
  - The fetch_btn_i synchroniser and debounce logic are removed.
  - fetch_btn_i is ignored.
- Undefined: the button-driven behaviour described above applies.

## Test plan
All scenarios use SyncStages = 2, ResetHoldCycles = 8, DebounceCycles = 4 and RtcDiv = 10.

- Lock at cycle 10:
  - state_o = 1 at cycle 13.
  - soc_rst_no rises at cycle 21.
  - fetch_en_o stays 0.
- Button bounce:
  - Stimulus in IDLE: fetch_btn_i toggles every 2 cycles for 20 cycles, then holds 1.
  - No acceptance during the bounce.
  - fetch_en_o rises exactly 7 cycles after the final rise (2 + 4 + 1).
- Button held through reset:
  - Stimulus: button held 1 from cycle 0, then lock.
  - state_o stays 2 with fetch_en_o = 0.
  - After release and a re-press, RUN is entered.
- Lock loss in RUN:
  - Stimulus: locked_i drops.
  - 3 cycles later: soc_rst_no = 0, fetch_en_o = 0, rtc_clk_o = 0, state_o = 0.
  - Re-lock repeats the 8-cycle hold.
- RTC divider:
  - In IDLE/RUN, rtc_clk_o toggles every 5 cycles (period 10, high 5 / low 5).
  - rtc_clk_o is constant 0 during RESET_HOLD.
- Autofetch and mid-run reset:
  - With SOC_BOOT_CTRL_AUTOFETCH_EN defined, fetch_en_o rises 1 cycle after soc_rst_no, with no button input.
  - rst_n pulsed low mid-RUN clears all outputs immediately.
